// File: rtl/render_stream_ctrl_pkg.sv
// render_stream_ctrl_pkg: shared pixel width, controller states and sizing helpers.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif
package render_stream_ctrl_pkg;
  localparam int CW = `COLOR_WIDTH;
  typedef logic [CW-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_e;
  function automatic int bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/render_stream_ctrl_sync_fifo.sv
// sync_fifo: first-word-fall-through return buffer with synchronous clear.
module sync_fifo import render_stream_ctrl_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_gen_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [bits(DEPTH):0]     count
);
  localparam int AW = bits(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem[rd_q];
  always_ff @(posedge clk or negedge rst_gen_n) begin
    if (!rst_gen_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + AW'(1);
      if (do_pop) rd_q <= (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_q] <= din;
  end
endmodule

// File: rtl/render_stream_ctrl.sv
// render_stream_ctrl: raster issue with credit flow control, in-order return buffering
// and packing of shaded pixels into framed output beats.
module render_stream_ctrl import render_stream_ctrl_pkg::*; #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int PPB        = 2,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_gen_n,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     abort,
  output logic [bits(H_RES)-1:0]   issue_x,
  output logic [bits(V_RES)-1:0]   issue_y,
  output logic                     issue_valid,
  input  logic                     ret_valid,
  input  pixel_t                   ret_shade,
  output logic [PPB*CW-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_sof,
  output logic                     m_eol,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
);
  localparam int XW  = bits(H_RES);
  localparam int YW  = bits(V_RES);
  localparam int BPL = H_RES / PPB;
  localparam int BW  = bits(BPL);
  localparam int FW  = bits(FIFO_DEPTH) + 1;
  localparam int IW  = bits(FIFO_DEPTH + 1);
  localparam int PW  = bits(PPB + 1);
  localparam int UW  = FW + 2;
  state_e state_q, state_d;
  logic [XW-1:0] ix_q, ix_d;
  logic [YW-1:0] iy_q, iy_d, by_q, by_d;
  logic [BW-1:0] bx_q, bx_d;
  logic [IW-1:0] inf_q, inf_d;
  logic [PW-1:0] pk_cnt_q, pk_cnt_d, base;
  logic [PPB*CW-1:0] pk_q, pk_d;
  logic ovf_q, ovf_d;
  logic [FW-1:0] f_cnt;
  logic f_full, f_empty, f_push, f_pop, clr;
  pixel_t f_dout;
  logic x_end, y_end, b_end, fire, frame_end, ret_take;
  logic [UW-1:0] used;
  // Packer occupancy is counted as buffered so credits cover every pixel slot downstream.
  assign used = UW'(f_cnt) + UW'(inf_q) + UW'(pk_cnt_q);
  assign x_end = ix_q == XW'(H_RES-1);
  assign y_end = iy_q == YW'(V_RES-1);
  assign b_end = bx_q == BW'(BPL-1);
  assign fire = m_valid && m_ready;
  assign frame_end = inf_q == '0 && f_empty && (pk_cnt_q == '0 || fire);
  assign clr = (abort && state_q != IDLE) || state_q == FLUSH;
  assign ret_take = ret_valid && inf_q != '0;
  assign f_push = ret_take && !f_full && !clr;
  assign f_pop = !f_empty && (pk_cnt_q != PW'(PPB) || fire) && !clr;
  assign issue_x = ix_q;
  assign issue_y = iy_q;
  assign m_data = pk_q;
  assign m_valid = pk_cnt_q == PW'(PPB);
  assign m_sof = m_valid && bx_q == '0 && by_q == '0;
  assign m_eol = m_valid && b_end;
  assign overflow = ovf_q;
  sync_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_gen_n(rst_gen_n), .clr(clr), .push(f_push), .din(ret_shade),
    .pop(f_pop), .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_cnt)
  );
  always_ff @(posedge clk or negedge rst_gen_n) begin
    if (!rst_gen_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && !abort) ? RUN : IDLE;
      RUN:     state_d = abort ? FLUSH : (issue_valid && x_end && y_end) ? DRAIN : RUN;
      DRAIN:   state_d = abort ? FLUSH : !frame_end ? DRAIN : continuous ? RUN : IDLE;
      default: state_d = (inf_q == '0) ? IDLE : FLUSH;
    endcase
  end
  always_comb begin
    issue_valid = state_q == RUN && !abort && used < UW'(FIFO_DEPTH);
    busy = state_q != IDLE;
    frame_done = state_q == DRAIN && !abort && frame_end;
  end
  always_comb begin
    base = fire ? '0 : pk_cnt_q;
    pk_d = pk_q;
    for (int i = 0; i < PPB; i++)
      if (f_pop && base == PW'(i)) pk_d[i*CW +: CW] = f_dout;
    pk_cnt_d = clr ? '0 : base + PW'(f_pop);
    inf_d = inf_q + IW'(issue_valid) - IW'(ret_take);
    // Returns drained by a flush are expected; only truly unmatched ones flag an error.
    ovf_d = ovf_q || (ret_valid && (inf_q == '0 || (f_full && state_q != FLUSH)));
    ix_d = (clr || state_q == IDLE) ? '0 : !issue_valid ? ix_q : x_end ? '0 : ix_q + XW'(1);
    iy_d = (clr || state_q == IDLE) ? '0 : !(issue_valid && x_end) ? iy_q : y_end ? '0 : iy_q + YW'(1);
    bx_d = clr ? '0 : !fire ? bx_q : b_end ? '0 : bx_q + BW'(1);
    by_d = clr ? '0 : !(fire && b_end) ? by_q : (by_q == YW'(V_RES-1)) ? '0 : by_q + YW'(1);
  end
  always_ff @(posedge clk or negedge rst_gen_n) begin
    if (!rst_gen_n) begin
      ix_q <= '0;
      iy_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      inf_q <= '0;
      pk_cnt_q <= '0;
      pk_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ix_q <= ix_d;
      iy_q <= iy_d;
      bx_q <= bx_d;
      by_q <= by_d;
      inf_q <= inf_d;
      pk_cnt_q <= pk_cnt_d;
      pk_q <= pk_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: doc/render_stream_ctrl.md
RENDER_STREAM_CTRL -- requirements
Module: render_stream_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 320, pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, lines per frame.
REQ-003 SHALL have parameter PPB, default 2, pixels per output beat (1, 2 or 4; H_RES mod PPB == 0).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, return-buffer entries in pixels (power of two, >= PPB).
REQ-005 SHALL have ports: clk in 1 system clock; rst_gen_n in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: start in 1 begin frame; continuous in 1 auto-restart after each frame; abort in 1 synchronous flush request.
REQ-007 SHALL have ports: issue_x out clog2(H_RES) column; issue_y out clog2(V_RES) row; issue_valid out 1 coordinate valid.
REQ-008 SHALL have ports: ret_valid in 1 pipeline result valid; ret_shade in `COLOR_WIDTH shaded pixel.
REQ-009 SHALL have ports: m_data out PPB*`COLOR_WIDTH packed pixels; m_valid out 1; m_ready in 1; m_sof out 1; m_eol out 1.
REQ-010 SHALL have ports: busy out 1; frame_done out 1 single-cycle pulse; overflow out 1 sticky error.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DRAIN, FLUSH.
REQ-012 IDLE->RUN on start; RUN->DRAIN when pixel (H_RES-1, V_RES-1) is issued; DRAIN->IDLE when in-flight==0, FIFO empty and last beat accepted; frame_done pulses on that cycle.
REQ-013 In DRAIN with continuous=1, exit SHALL go to RUN at (0,0) instead of IDLE; frame_done still pulses.
REQ-014 issue_valid SHALL assert only in RUN and only when credits>0, credits = FIFO_DEPTH - fifo_count - in_flight.
REQ-015 Issue SHALL scan raster order: x increments per issue, wraps to 0 at H_RES-1 with y incrementing.
REQ-016 The downstream pipeline has no backpressure; each issue_valid cycle SHALL count as one issued pixel; in_flight increments on issue, decrements on ret_valid, unchanged when both occur.
REQ-017 ret_valid SHALL write ret_shade into the FIFO in arrival order; ret_valid with FIFO full or in_flight==0 SHALL set overflow and drop the data.
REQ-018 Packer SHALL pop PPB pixels into one beat, pixel 0 in bits [`COLOR_WIDTH-1:0], and present m_valid only with a complete beat.
REQ-019 m_data, m_sof, m_eol SHALL hold stable while m_valid=1 and m_ready=0; transfer occurs on m_valid & m_ready.
REQ-020 m_sof SHALL mark the first beat of each frame; m_eol SHALL mark every (H_RES/PPB)-th beat of a line.
REQ-021 Output beat/line counters SHALL wrap at H_RES/PPB and V_RES independently of the issue counters.
REQ-022 abort in any state except IDLE SHALL enter FLUSH: issue stops, FIFO and packer clear, m_valid drops next cycle, returns arriving while in_flight>0 are discarded without overflow; FLUSH->IDLE when in_flight==0.
REQ-023 start during RUN/DRAIN SHALL be ignored; abort and start together SHALL favour abort.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Issue-to-FIFO latency SHALL be external and arbitrary; FIFO-to-m_valid latency SHALL be at most 1 cycle after the PPB-th pixel is written.

Reset
REQ-026 rst_gen_n low SHALL asynchronously force IDLE, issue_valid=0, m_valid=0, m_sof=0, m_eol=0, busy=0, frame_done=0, overflow=0, all counters 0, FIFO empty.
REQ-027 overflow SHALL clear only by reset.

Structure
REQ-028 Beat type and the packing/credit width helper constants SHALL live in common_defs.svh/vector_pkg.svh alongside `COLOR_WIDTH; no module-local color typedefs.
REQ-029 Return buffer SHALL be a separate sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, full, empty, count).

Verification
REQ-030 H_RES=8,V_RES=2,PPB=2,fixed 5-cycle return delay, m_ready=1: exactly 8 beats, sof on beat 0, eol on beats 3 and 7, frame_done once, overflow=0.
REQ-031 FIFO_DEPTH=4, m_ready=0 held 50 cycles: issues stop after 4 pixels; release gives data intact in order.
REQ-032 m_ready toggled random 50%: m_data stable on every stalled cycle; pixel sequence equals ret_shade sequence.
REQ-033 abort with 3 pixels in flight: m_valid=0 next cycle, 3 returns discarded, overflow=0, IDLE after last return.
REQ-034 continuous=1, two frames: second sof beat follows first frame's last eol beat; frame_done pulses twice.
REQ-035 Spurious ret_valid with in_flight==0: overflow=1 and stays 1 until rst_gen_n low.
